// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART receive datapath
// Contents:
//   UART_DATA_W        - width of one received byte
//   DEFAULT_DEPTH_LOG2 - default log2 of the receive buffer depth
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector with configurable reset value
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   din  - level input, synchronous to clk
//   rise - high in the cycle where din is high and was low at the previous edge
// Parameters:
//   RESET_VAL - value the history flop takes in reset; 1 suppresses an edge
//               for an input that is already high when reset releases
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= RESET_VAL;
    end else begin
      din_q <= din_d;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte buffer between the UART receiver and its consumers
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous reset, active-high
//   I_DATA   - received byte, stable while NrD is high
//   NrD      - new-byte level from the receiver; each rising edge is one byte
//   rd_en    - consumer pops / requests one byte
//   ovf_clr  - clears the sticky overflow flag
//   O_DATA   - byte to consumer
//   O_VALID  - O_DATA holds a valid byte
//   empty    - no bytes stored
//   full     - 2^DEPTH_LOG2 bytes stored
//   level    - bytes stored, 0..2^DEPTH_LOG2
//   overflow - sticky, at least one byte dropped since last clear/reset
// Build option:
//   UART_RX_FIFO_FWFT_EN defined   - first-word-fall-through read port
//   UART_RX_FIFO_FWFT_EN undefined - registered read, one-cycle O_VALID pulse
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] I_DATA,
  input  logic                   NrD,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic [UART_DATA_W-1:0] O_DATA,
  output logic                   O_VALID,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                   wr_req;
  logic                   do_wr;
  logic                   do_pop;
  logic                   drop;

  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    level_q,  level_d;
  logic                   ovf_q,    ovf_d;
  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  // History flop resets high so a NrD already asserted at reset release is not a byte.
  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_nrd_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (NrD),
    .rise (wr_req)
  );

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LEVEL);
  assign level    = level_q;
  assign overflow = ovf_q;

  // A write into a full buffer still lands when a pop frees the slot at the same edge.
  assign do_pop = rd_en & ~empty;
  assign do_wr  = wr_req & (~full | do_pop);
  assign drop   = wr_req & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_wr, do_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // Set beats clear when a drop and ovf_clr coincide.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; after reset the zeroed level makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= I_DATA;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign O_DATA  = empty ? '0 : mem_q[rd_ptr_q];
  assign O_VALID = ~empty;
`else
  logic [UART_DATA_W-1:0] odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;

  always_comb begin
    odata_d  = odata_q;
    ovalid_d = do_pop;
    if (do_pop) begin
      odata_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign O_DATA  = odata_q;
  assign O_VALID = ovalid_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver in the sniffer datapath. Detects each new-byte indication from the receiver, stores the byte in a circular buffer, and presents bytes to the consuming logic (command decoder / USB capture control) through a read handshake. Provides full/empty/level status and a sticky overflow flag so no receive loss goes unnoticed.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth in bytes (depth = 2^DEPTH_LOG2; legal 2..8)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- I_DATA  input  8  received byte from UART receiver, stable while NrD high
- NrD  input  1  new-byte indication from UART receiver, level, synchronous to clk; a rising edge marks one byte
- rd_en  input  1  consumer pops/requests one byte
- ovf_clr  input  1  clears sticky overflow flag
- O_DATA  output  8  byte to consumer
- O_VALID  output  1  O_DATA holds a valid byte (meaning per Configuration)
- empty  output  1  no bytes stored
- full  output  1  2^DEPTH_LOG2 bytes stored
- level  output  DEPTH_LOG2+1  bytes stored, 0..2^DEPTH_LOG2
- overflow  output  1  sticky: at least one byte dropped since last clear/reset

## Operation
- Write detect: nrd_q <= NrD each cycle; wr_req = NrD & ~nrd_q. One write per rising edge regardless of NrD high time.
- nrd_q resets to 1: NrD already high at reset release produces no write.
- wr_req and not full: mem[wr_ptr] <= I_DATA, wr_ptr++.
- wr_req and full: if a pop succeeds same cycle, write accepted (level unchanged, no overflow); otherwise byte dropped, overflow <= 1, pointers/level unchanged.
- Pop: rd_en and not empty -> rd_ptr++. rd_en while empty ignored, no error flag.
- Simultaneous write and pop when empty: write accepted, pop ignored; level becomes 1.
- Pointers DEPTH_LOG2 bits, wrap modulo depth; level tracked as separate counter: +1 write only, -1 pop only, unchanged both/neither. empty = (level==0), full = (level==2^DEPTH_LOG2), both registered-derived.
- overflow: set on drop, cleared by ovf_clr; set and clear same cycle -> set wins.
- Reset (any time, including mid-transfer): pointers 0, level 0, empty 1, full 0, overflow 0, O_DATA 8'h00, O_VALID 0; stored contents discarded.

## Timing
- NrD rising at edge N sampled -> wr_req during cycle N -> level/empty updated at edge N+1. NrD-to-empty-deassert latency 1 clk.
- Status outputs change only on clk edges; level, empty, full consistent in every cycle.
- Back-to-back bytes: minimum NrD period 2 clk (high 1, low 1); UART byte rate is far below this.
- Read latency per Configuration.

## Configuration
- Macro UART_RX_FIFO_FWFT_EN.
- Defined (first-word-fall-through): O_DATA = mem[rd_ptr] when not empty, 8'h00 when empty; O_VALID = ~empty. rd_en acknowledges the currently shown byte; next byte visible the following cycle.
- Undefined (registered read): rd_en and not empty at edge N -> O_DATA <= mem[rd_ptr], O_VALID = 1 for cycle N+1 only (single-cycle pulse); O_DATA holds last value afterwards. rd_en while empty -> O_VALID stays 0.
- Status/overflow behaviour identical in both modes.

## Structure
- Shared package uart_pkg: UART_DATA_W = 8, default DEPTH_LOG2.
- Sub-module rise_detect (registered rising-edge detector, configurable reset value) used for NrD; storage inferred inline as distributed/block RAM array.

## Test plan
- Reset with NrD held high, release -> no write; level 0, empty 1, overflow 0.
- Three NrD pulses with 8'hA5, 8'h3C, 8'hFF -> level 3; three pops return A5, 3C, FF in order (FWFT: visible before rd_en; registered: O_VALID pulse 1 cycle after each rd_en); empty 1 at end.
- NrD held high 20 cycles with 8'h11 -> exactly one byte stored, level 1.
- DEPTH_LOG2=2: fill 4 bytes (full 1), 5th NrD pulse 8'h77 -> dropped, overflow 1, level 4; pop all -> original 4 bytes; ovf_clr -> overflow 0.
- Full buffer, NrD edge with rd_en same cycle -> level stays 4, overflow 0, new byte read last; ovf_clr coincident with a drop -> overflow 1.
- Pointer wrap: 40 write/pop pairs with DEPTH_LOG2=2, incrementing data 0..39 -> all read in order; assert rst mid-stream -> level 0, O_VALID 0 next cycle.
